// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state types and defaults for uart_buffered.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DEFAULT_CLK_DIV = 434;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// rtl/uart_buffered.sv - UART with CTS-gated transmitter and FIFO-buffered receiver.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
module uart_buffered
  import uart_pkg::*;
#(
  parameter int CLK_DIV       = UART_DEFAULT_CLK_DIV,
  parameter int DATA_BITS     = 8,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_pop,
  output logic                 rx_overflow,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 err_clear,
  input  logic                 cts_n,
  output logic                 rts
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int FCW   = $clog2(RX_FIFO_DEPTH) + 1;

  if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_params
    $error("uart_buffered: illegal parameter value");
  end

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_line;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick  = (tx_cnt == CNT_W'(CLK_DIV - 1));
  assign tx_ready = (tx_state == TX_IDLE) & ~cts_n;
  assign tx_busy  = (tx_state != TX_IDLE);
  assign tx       = tx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tx_state != TX_IDLE) tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_valid && tx_ready) begin
          tx_shift <= tx_data;
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_line  <= 1'b0;
          tx_state <= TX_START;
`ifdef UART_PARITY_EN
          tx_par   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
        TX_START: if (tx_tick) begin
          tx_line  <= tx_shift[0];
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_tick) begin
          if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
            tx_bit <= '0;
`ifdef UART_PARITY_EN
            tx_line  <= tx_par;
            tx_state <= TX_PARITY;
`else
            tx_line  <= 1'b1;
            tx_state <= TX_STOP;
`endif
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (tx_tick) begin
          tx_line  <= 1'b1;
          tx_state <= TX_STOP;
        end
`endif
        TX_STOP: if (tx_tick) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t            rx_state;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_half, rx_full, stop_tick;
  logic                 push_pending;
  logic                 frame_set, parity_set, ovf_set;
  logic                 fifo_full;
  logic [FCW-1:0]       fifo_count;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
`endif

  assign rx_half   = (rx_cnt == CNT_W'(CLK_DIV / 2 - 1));
  assign rx_full   = (rx_cnt == CNT_W'(CLK_DIV - 1));
  assign stop_tick = (rx_state == RX_STOP) & rx_full;
  assign frame_set = stop_tick & ~rx_s2;
`ifdef UART_PARITY_EN
  assign parity_set = stop_tick & rx_par_bad;
`else
  assign parity_set = 1'b0;
`endif
  assign ovf_set = push_pending & fifo_full & ~(rx_pop & rx_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // A stop-bit error drops back to IDLE; a held-low line yields no new 1->0 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      push_pending <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad   <= 1'b0;
`endif
    end else begin
      push_pending <= 1'b0;
      if (rx_state != RX_IDLE) rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_half) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
          rx_par_bad <= 1'b0;
`endif
        end
        RX_DATA: if (rx_full) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_state <= RX_PARITY;
`else
            rx_state <= RX_STOP;
`endif
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (rx_full) begin
          rx_cnt     <= '0;
          rx_par_bad <= ((^rx_shift) ^ rx_s2) != (PARITY_ODD != 0);
          rx_state   <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_full) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
`ifdef UART_PARITY_EN
          push_pending <= rx_s2 & ~rx_par_bad;
`else
          push_pending <= rx_s2;
`endif
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Setting wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow   <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      if (ovf_set)         rx_overflow   <= 1'b1;
      else if (err_clear)  rx_overflow   <= 1'b0;
      if (frame_set)       rx_frame_err  <= 1'b1;
      else if (err_clear)  rx_frame_err  <= 1'b0;
      if (parity_set)      rx_parity_err <= 1'b1;
      else if (err_clear)  rx_parity_err <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_pending),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .valid     (rx_valid),
    .head      (rx_data),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rts = (fifo_count <= FCW'(RX_FIFO_DEPTH - 2));

endmodule
